// File: rtl/axi4s_prbs_err_mon_if.sv
// AXI4-Stream bundle carrying PRBS error words (1 = bit error) into the monitor.
interface axi4s_prbs_err_mon_if #(
  parameter int TDATA_WIDTH = 8
) ();
  logic                   target_tvalid;
  logic                   target_tready;
  logic [TDATA_WIDTH-1:0] target_tdata;
  logic                   target_tlast;

  modport master (output target_tvalid, target_tdata, target_tlast, input target_tready);
  modport slave  (input target_tvalid, target_tdata, target_tlast, output target_tready);
endinterface

// File: rtl/axi4s_prbs_err_mon.sv
// PRBS error monitor: two-stage popcount pipeline feeding a SEARCH/LOCKED
// tracker and saturating bit/error/frame/loss counters for BER readout.
module axi4s_prbs_err_mon #(
  parameter int TDATA_WIDTH = 8,
  parameter int CNT_WIDTH   = 32,
  parameter int LOCK_CNT    = 16,
  parameter int LOSS_THRESH = 4
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       clear,
  axi4s_prbs_err_mon_if.slave        target,
  output logic                       locked,
  output logic [CNT_WIDTH-1:0]       bit_cnt,
  output logic [CNT_WIDTH-1:0]       err_cnt,
  output logic [CNT_WIDTH-1:0]       frame_cnt,
  output logic [CNT_WIDTH-1:0]       loss_cnt
);
  localparam int PW  = $clog2(TDATA_WIDTH + 1);
  localparam int OKW = $clog2(LOCK_CNT + 1);
  localparam int BDW = $clog2(LOSS_THRESH + 1);
  localparam logic [CNT_WIDTH-1:0] CMAX    = '1;
  localparam logic [CNT_WIDTH:0]   BIT_INC = (CNT_WIDTH+1)'(TDATA_WIDTH);

  typedef enum logic {S_SEARCH = 1'b0, S_LOCKED = 1'b1} state_t;

  logic                   r_ready;
  logic [1:0]             r_vld_pipe;
  logic [TDATA_WIDTH-1:0] r_s1_data;
  logic                   r_s1_last;
  logic [PW-1:0]          r_s2_pop;
  logic                   r_s2_last;
  state_t                 r_state;
  logic [OKW-1:0]         r_ok_run;
  logic [BDW-1:0]         r_bad_run;
  logic [CNT_WIDTH-1:0]   r_bit_cnt, r_err_cnt, r_frame_cnt, r_loss_cnt;

  logic                   w_accept;
  logic [PW-1:0]          w_pop;
  logic                   w_beat, w_perr, w_ok_hit, w_bad_hit;
  state_t                 w_state_nxt;
  logic                   w_count, w_loss;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [CNT_WIDTH:0]   b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + b;
    return s[CNT_WIDTH] ? CMAX : s[CNT_WIDTH-1:0];
  endfunction

  assign w_accept             = target.target_tvalid && r_ready;
  assign target.target_tready = r_ready;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < TDATA_WIDTH; i++) w_pop = w_pop + PW'(r_s1_data[i]);
  end

  // Stage 1 holds the accepted beat, stage 2 its popcount; no back-pressure.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_ready    <= 1'b0;
      r_vld_pipe <= '0;
      r_s1_data  <= '0;
      r_s1_last  <= 1'b0;
      r_s2_pop   <= '0;
      r_s2_last  <= 1'b0;
    end else begin
      r_ready    <= 1'b1;
      r_vld_pipe <= {r_vld_pipe[0], w_accept};
      r_s1_data  <= target.target_tdata;
      r_s1_last  <= target.target_tlast;
      r_s2_pop   <= w_pop;
      r_s2_last  <= r_s1_last;
    end
  end

  assign w_beat    = r_vld_pipe[1];
  assign w_perr    = (r_s2_pop != '0);
  assign w_ok_hit  = (r_ok_run  == OKW'(LOCK_CNT - 1));
  assign w_bad_hit = (r_bad_run == BDW'(LOSS_THRESH - 1));

  always_ff @(posedge aclk) begin
    if (areset) r_state <= S_SEARCH;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_SEARCH: if (w_beat && !w_perr && w_ok_hit) w_state_nxt = S_LOCKED;
      S_LOCKED: if (w_beat &&  w_perr && w_bad_hit) w_state_nxt = S_SEARCH;
      default:  w_state_nxt = S_SEARCH;
    endcase
  end

  always_comb begin
    locked  = (r_state == S_LOCKED);
    w_count = w_beat && (r_state == S_LOCKED);
    w_loss  = w_count && w_perr && w_bad_hit;
  end

  // Runs only move on processed beats, so idle cycles never break a run.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_ok_run  <= '0;
      r_bad_run <= '0;
    end else if (w_beat) begin
      if (r_state == S_SEARCH) r_ok_run  <= (w_perr || w_ok_hit)   ? '0 : r_ok_run + 1'b1;
      else                     r_bad_run <= (!w_perr || w_bad_hit) ? '0 : r_bad_run + 1'b1;
    end
  end

  // clear outranks a same-edge beat or loss event; FSM state is unaffected.
  always_ff @(posedge aclk) begin
    if (areset || clear) begin
      r_bit_cnt   <= '0;
      r_err_cnt   <= '0;
      r_frame_cnt <= '0;
      r_loss_cnt  <= '0;
    end else begin
      if (w_count) begin
        r_bit_cnt   <= sat_add(r_bit_cnt, BIT_INC);
        r_err_cnt   <= sat_add(r_err_cnt, (CNT_WIDTH+1)'(r_s2_pop));
        r_frame_cnt <= sat_add(r_frame_cnt, (CNT_WIDTH+1)'(r_s2_last));
      end
      if (w_loss) r_loss_cnt <= sat_add(r_loss_cnt, (CNT_WIDTH+1)'(1));
    end
  end

  assign bit_cnt   = r_bit_cnt;
  assign err_cnt   = r_err_cnt;
  assign frame_cnt = r_frame_cnt;
  assign loss_cnt  = r_loss_cnt;
endmodule

// File: tb/tb_axi4s_prbs_err_mon.sv
// Bench for axi4s_prbs_err_mon: per-beat scoreboard against a beat-level model,
// a table of stream segments with hand-computed totals, and reset/bubble sequences.
module tb_axi4s_prbs_err_mon;
  localparam int W    = 8;
  localparam int CW   = 8;
  localparam int LOCK = 16;
  localparam int LOSS = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          aclk = 1'b0;
  logic          areset, clear;
  logic          locked;
  logic [CW-1:0] bit_cnt, err_cnt, frame_cnt, loss_cnt;

  axi4s_prbs_err_mon_if #(.TDATA_WIDTH(W)) tif ();

  axi4s_prbs_err_mon #(
    .TDATA_WIDTH(W), .CNT_WIDTH(CW), .LOCK_CNT(LOCK), .LOSS_THRESH(LOSS)
  ) dut (
    .aclk(aclk), .areset(areset), .clear(clear), .target(tif),
    .locked(locked), .bit_cnt(bit_cnt), .err_cnt(err_cnt),
    .frame_cnt(frame_cnt), .loss_cnt(loss_cnt)
  );

  always #5 aclk = ~aclk;

  typedef struct { bit lk; int unsigned b, e, f, l; } exp_t;
  typedef struct {
    int n; logic [7:0] d0, d1; bit last, clr, lk; int unsigned b, e, f, l;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        tv[16];
  int          checks = 0, fails = 0;
  bit [2:0]    hs_p = '0;
  bit [1:0]    clr_p = '0;
  bit          m_lock = 1'b0;
  int          m_ok = 0, m_bad = 0;
  int unsigned m_b = 0, m_e = 0, m_f = 0, m_l = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int unsigned msat(input int unsigned a, input int unsigned b);
    return (a + b > CMAX) ? CMAX : a + b;
  endfunction

  task automatic model_reset();
    m_lock = 1'b0; m_ok = 0; m_bad = 0;
    m_b = 0; m_e = 0; m_f = 0; m_l = 0;
  endtask

  task automatic model_beat(input logic [7:0] d, input bit l, input bit c);
    int   p;
    exp_t x;
    p = $countones(d);
    if (!m_lock) begin
      if (p != 0) m_ok = 0;
      else begin
        m_ok++;
        if (m_ok == LOCK) begin m_lock = 1'b1; m_ok = 0; end
      end
    end else begin
      m_b = msat(m_b, W);
      m_e = msat(m_e, p);
      m_f = msat(m_f, l);
      if (p != 0) begin
        m_bad++;
        if (m_bad == LOSS) begin m_lock = 1'b0; m_bad = 0; m_l = msat(m_l, 1); end
      end else m_bad = 0;
    end
    if (c) begin m_b = 0; m_e = 0; m_f = 0; m_l = 0; end
    x = '{m_lock, m_b, m_e, m_f, m_l};
    sb_q.push_back(x);
  endtask

  // One clock: compare the beat that finished on the last edge, then drive.
  task automatic cycle(input bit vld, input logic [7:0] d, input bit l, input bit cwb,
                       input bit cnow, input bit rst, output bit hs);
    exp_t x;
    @(negedge aclk);
    if (hs_p[2]) begin
      if (sb_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL sb_underflow actual=empty expected=entry");
      end else begin
        x = sb_q.pop_front();
        chk("beat_locked", locked, x.lk);
        chk("beat_bit_cnt", bit_cnt, x.b);
        chk("beat_err_cnt", err_cnt, x.e);
        chk("beat_frame_cnt", frame_cnt, x.f);
        chk("beat_loss_cnt", loss_cnt, x.l);
      end
    end
    areset            = rst;
    tif.target_tvalid = vld;
    tif.target_tdata  = d;
    tif.target_tlast  = l;
    clear             = cnow | clr_p[1];
    hs                = vld && (tif.target_tready === 1'b1) && !rst;
    clr_p             = {clr_p[0], hs && cwb};
    hs_p              = {hs_p[1:0], hs};
    if (hs) model_beat(d, l, cwb);
    if (cnow && !rst) begin m_b = 0; m_e = 0; m_f = 0; m_l = 0; end
    if (rst) begin
      sb_q.delete(); hs_p = '0; clr_p = '0; model_reset();
    end
  endtask

  task automatic idle();
    bit hs;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, hs);
  endtask

  task automatic send(input logic [7:0] d, input bit l, input bit cwb);
    bit hs;
    int n = 0;
    do begin
      cycle(1'b1, d, l, cwb, 1'b0, 1'b0, hs);
      n++;
    end while (!hs && n < 16);
    if (!hs) begin
      checks++; fails++;
      $display("FAIL send_timeout actual=no_handshake expected=handshake");
    end
  endtask

  task automatic chk_outs(input string nm, input bit lk, input int unsigned b,
                          input int unsigned e, input int unsigned f, input int unsigned l);
    chk({nm, "_locked"}, locked, lk);
    chk({nm, "_bit"}, bit_cnt, b);
    chk({nm, "_err"}, err_cnt, e);
    chk({nm, "_frame"}, frame_cnt, f);
    chk({nm, "_loss"}, loss_cnt, l);
  endtask

  initial begin
    bit hs;
    // n, d0(even beats), d1(odd beats), tlast, clear-on-last-beat, locked, bit, err, frame, loss
    tv[0]  = '{20, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1,  32,   0, 0, 0};
    tv[1]  = '{ 1, 8'h81, 8'h81, 1'b0, 1'b0, 1'b1,  40,   2, 0, 0};
    tv[2]  = '{ 1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1,  48,   2, 0, 0};
    tv[3]  = '{ 3, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1,  72,  26, 0, 0};
    tv[4]  = '{ 1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1,  80,  26, 0, 0};
    tv[5]  = '{ 4, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 112,  58, 0, 1};
    tv[6]  = '{16, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 112,  58, 0, 1};
    tv[7]  = '{ 0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1,   0,   0, 0, 0};
    tv[8]  = '{80, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b1, 255, 160, 0, 0};
    tv[9]  = '{48, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b1, 255, 255, 0, 0};
    tv[10] = '{ 1, 8'h03, 8'h03, 1'b1, 1'b1, 1'b1,   0,   0, 0, 0};
    tv[11] = '{ 3, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1,  24,   0, 3, 0};
    tv[12] = '{ 2, 8'h01, 8'h01, 1'b1, 1'b0, 1'b1,  40,   2, 5, 0};
    tv[13] = '{ 2, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0,   0,   0, 0, 0};
    tv[14] = '{16, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1,   0,   0, 0, 0};
    tv[15] = '{ 4, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1,  32,   0, 4, 0};

    areset = 1'b1; clear = 1'b0;
    tif.target_tvalid = 1'b0; tif.target_tdata = '0; tif.target_tlast = 1'b0;

    repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, hs);
    chk("rst_tready", tif.target_tready, 0);
    chk_outs("rst", 1'b0, 0, 0, 0, 0);
    idle();
    chk("rst_release_tready_low", tif.target_tready, 0);
    idle();
    chk("rst_release_tready_high", tif.target_tready, 1);

    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < tv[t].n; i++)
        send((i % 2) ? tv[t].d1 : tv[t].d0, tv[t].last, tv[t].clr && (i == tv[t].n - 1));
      if (tv[t].n == 0 && tv[t].clr) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, hs);
      repeat (4) idle();
      chk_outs($sformatf("vec%0d", t), tv[t].lk, tv[t].b, tv[t].e, tv[t].f, tv[t].l);
    end

    // Reset pulse with errored beats still in the pipeline.
    repeat (3) send(8'h55, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, hs);
    idle();
    chk("midrst_tready_low", tif.target_tready, 0);
    chk_outs("midrst", 1'b0, 0, 0, 0, 0);
    idle();
    chk("midrst_tready_high", tif.target_tready, 1);
    repeat (2) idle();
    chk_outs("midrst_flushed", 1'b0, 0, 0, 0, 0);

    // Lock with idle bubbles between beats; lock lands exactly on beat 16.
    for (int i = 0; i < LOCK - 1; i++) begin
      send(8'h00, 1'b0, 1'b0);
      repeat (2) idle();
    end
    repeat (3) idle();
    chk("bubble_pre_lock", locked, 0);
    send(8'h00, 1'b0, 1'b0);
    idle();
    idle();
    chk("bubble_lock_t2", locked, 0);
    idle();
    chk("bubble_lock_t3", locked, 1);
    chk("bubble_lock_beat_uncounted", bit_cnt, 0);

    repeat (4) idle();
    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
